// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage.
//   if_state_t        : fetch FSM state encoding (RUN / HALTED)
//   DEFAULT_RESET_PC  : default first fetch address after reset
//   DEFAULT_HALT_WORD : default instruction encoding treated as HALT
//   PC_INCR           : byte increment between sequential 16-bit words
package instruction_fetch_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } if_state_t;

    localparam logic [15:0] DEFAULT_RESET_PC  = 16'h0000;
    localparam logic [15:0] DEFAULT_HALT_WORD = 16'h0000;
    localparam logic [15:0] PC_INCR           = 16'd2;

endpackage

// File: rtl/instruction_fetch_if_id_buffer.sv
// IF/ID pipeline register.
//   clk, rst_n          : clock, async active-low reset
//   load                : capture instr_in / pc_plus2_in as a valid entry
//   flush               : clear to an empty (invalid, zeroed) entry; wins over all
//   hold                : keep current contents; wins over load
//   instr_in            : fetched instruction word
//   pc_plus2_in         : fetch address + 2
//   ifid_instruction    : buffered instruction
//   ifid_pc_plus2       : buffered fetch address + 2
//   ifid_valid          : buffer holds a real instruction
module if_id_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic        hold,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_plus2_in,
    output logic [15:0] ifid_instruction,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instruction <= 16'h0000;
            ifid_pc_plus2    <= 16'h0000;
            ifid_valid       <= 1'b0;
        end else if (flush) begin
            ifid_instruction <= 16'h0000;
            ifid_pc_plus2    <= 16'h0000;
            ifid_valid       <= 1'b0;
        end else if (!hold && load) begin
            ifid_instruction <= instr_in;
            ifid_pc_plus2    <= pc_plus2_in;
            ifid_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, RUN/HALTED FSM and IF/ID buffer.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RUN     | fetching one word per unstalled cycle, PC advances by 2
//   HALTED  | a HALT_WORD was fetched; PC frozen, IF/ID empty until branch
//
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   stall             : hold PC, IF/ID, state and fetch_count
//   branch_taken      : redirect to branch_target (highest priority)
//   branch_target     : redirect byte address, bit 0 is dropped
//   instruction       : memory word for from_pc (combinational)
//   from_pc           : fetch address (PC register)
//   ifid_instruction  : IF/ID instruction
//   ifid_pc_plus2     : IF/ID fetch address + 2
//   ifid_valid        : IF/ID holds a real instruction
//   halted            : FSM is in HALTED
//   misalign          : one-cycle pulse after an odd branch_target is taken
//   fetch_count       : saturating count of words loaded into IF/ID
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [15:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] instruction,
    output logic [15:0] from_pc,
    output logic [15:0] ifid_instruction,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign,
    output logic [15:0] fetch_count
);

    if_state_t   state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] count_q, count_d;
    logic        misalign_q, misalign_d;
    logic        buf_load, buf_flush, buf_hold;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc_q + PC_INCR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        misalign_d = 1'b0;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;
        buf_hold   = 1'b0;

        if (branch_taken) begin
            pc_d       = {branch_target[15:1], 1'b0};
            misalign_d = branch_target[0];
            buf_flush  = 1'b1;
            state_d    = ST_RUN;
        end else if (stall) begin
            buf_hold = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    buf_load = 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    // The HALT word itself enters IF/ID; PC stays on it.
                    if (instruction == HALT_WORD) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end
                ST_HALTED: begin
                    buf_flush = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            count_q    <= 16'h0000;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_buffer u_if_id_buffer (
        .clk              (clk),
        .rst_n            (rst_n),
        .load             (buf_load),
        .flush            (buf_flush),
        .hold             (buf_hold),
        .instr_in         (instruction),
        .pc_plus2_in      (pc_plus2),
        .ifid_instruction (ifid_instruction),
        .ifid_pc_plus2    (ifid_pc_plus2),
        .ifid_valid       (ifid_valid)
    );

    assign from_pc     = pc_q;
    assign halted      = (state_q == ST_HALTED);
    assign misalign    = misalign_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] instruction;
    logic [15:0] from_pc;
    logic [15:0] ifid_instruction;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
    logic        misalign;
    logic [15:0] fetch_count;

    int total  = 0;
    int passed = 0;

    instruction_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .instruction      (instruction),
        .from_pc          (from_pc),
        .ifid_instruction (ifid_instruction),
        .ifid_pc_plus2    (ifid_pc_plus2),
        .ifid_valid       (ifid_valid),
        .halted           (halted),
        .misalign         (misalign),
        .fetch_count      (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard program image: a few fixed words, HALT (0000) at 003E,
    // every other address holds 1000+addr (never zero in the tested range).
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'hFE21;
            16'h0010: return 16'hCE9A;
            16'h002C: return 16'hF111;
            16'h003E: return 16'h0000;
            default:  return 16'h1000 + a;
        endcase
    endfunction

    always_comb instruction = mem_word(from_pc);

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic        halted;
        logic        mis;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic void add(input logic s, input logic b, input logic [15:0] t,
                                input logic [15:0] pc, input logic [15:0] ins,
                                input logic [15:0] pc2, input logic v, input logic h,
                                input logic m, input logic [15:0] c);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.pc = pc; r.instr = ins; r.pc2 = pc2;
        r.valid = v; r.halted = h; r.mis = m; r.cnt = c;
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input int step,
                         input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
        else
            passed++;
    endtask

    task automatic check_all(input int step, input vec_t e);
        check("from_pc",          step, from_pc,          e.pc);
        check("ifid_instruction", step, ifid_instruction, e.instr);
        check("ifid_pc_plus2",    step, ifid_pc_plus2,    e.pc2);
        check("ifid_valid",       step, {15'd0, ifid_valid}, {15'd0, e.valid});
        check("halted",           step, {15'd0, halted},     {15'd0, e.halted});
        check("misalign",         step, {15'd0, misalign},   {15'd0, e.mis});
        check("fetch_count",      step, fetch_count,      e.cnt);
    endtask

    task automatic check_reset(input int tag);
        vec_t r;
        r.stall = 0; r.br = 0; r.tgt = 0; r.pc = 16'h0000; r.instr = 0; r.pc2 = 0;
        r.valid = 0; r.halted = 0; r.mis = 0; r.cnt = 0;
        check_all(tag, r);
    endtask

    // Drive each vector just after a rising edge, queue its expectation,
    // then compare once the next edge has updated the DUT.
    task automatic run_table(input int base);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            stall        = 1'b0;
            branch_taken = 1'b0;
            e = sb.pop_front();
            check_all(base + i, e);
        end
        vecs.delete();
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;

        #2;
        check_reset(9000);
        repeat (2) @(posedge clk);
        #1;
        check_reset(9001);
        rst_n = 1'b1;

        // Sequential fetch from reset through the HALT word at 003E.
        for (int i = 1; i <= 32; i++) begin
            logic [15:0] p;
            p = 16'(2 * i);
            add(0, 0, 16'h0000, (i < 32) ? p : 16'h003E, mem_word(16'(2 * (i - 1))),
                p, 1, (i == 32), 0, 16'(i));
        end
        //  s  b  tgt       pc        instr     pc2       v  h  m  cnt
        add(0, 0, 16'h0000, 16'h003E, 16'h0000, 16'h0000, 0, 1, 0, 16'd32);
        add(0, 0, 16'h0000, 16'h003E, 16'h0000, 16'h0000, 0, 1, 0, 16'd32);
        // Branch out of HALTED.
        add(0, 1, 16'h002C, 16'h002C, 16'h0000, 16'h0000, 0, 0, 0, 16'd32);
        add(0, 0, 16'h0000, 16'h002E, 16'hF111, 16'h002E, 1, 0, 0, 16'd33);
        add(0, 1, 16'h000C, 16'h000C, 16'h0000, 16'h0000, 0, 0, 0, 16'd33);
        add(0, 0, 16'h0000, 16'h000E, 16'h100C, 16'h000E, 1, 0, 0, 16'd34);
        add(0, 0, 16'h0000, 16'h0010, 16'h100E, 16'h0010, 1, 0, 0, 16'd35);
        // Three-cycle stall at 0010.
        add(1, 0, 16'h0000, 16'h0010, 16'h100E, 16'h0010, 1, 0, 0, 16'd35);
        add(1, 0, 16'h0000, 16'h0010, 16'h100E, 16'h0010, 1, 0, 0, 16'd35);
        add(1, 0, 16'h0000, 16'h0010, 16'h100E, 16'h0010, 1, 0, 0, 16'd35);
        add(0, 0, 16'h0000, 16'h0012, 16'hCE9A, 16'h0012, 1, 0, 0, 16'd36);
        // Branch + stall together, odd target.
        add(1, 1, 16'h0023, 16'h0022, 16'h0000, 16'h0000, 0, 0, 1, 16'd36);
        add(0, 0, 16'h0000, 16'h0024, 16'h1022, 16'h0024, 1, 0, 0, 16'd37);
        // HALT word under stall must not halt; it halts once released.
        add(0, 1, 16'h003E, 16'h003E, 16'h0000, 16'h0000, 0, 0, 0, 16'd37);
        add(1, 0, 16'h0000, 16'h003E, 16'h0000, 16'h0000, 0, 0, 0, 16'd37);
        add(0, 0, 16'h0000, 16'h003E, 16'h0000, 16'h0040, 1, 1, 0, 16'd38);
        add(0, 1, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0, 16'd38);
        add(0, 0, 16'h0000, 16'h0012, 16'hCE9A, 16'h0012, 1, 0, 0, 16'd39);
        add(0, 0, 16'h0000, 16'h0014, 16'h1012, 16'h0014, 1, 0, 0, 16'd40);
        add(0, 0, 16'h0000, 16'h0016, 16'h1014, 16'h0016, 1, 0, 0, 16'd41);
        add(0, 0, 16'h0000, 16'h0018, 16'h1016, 16'h0018, 1, 0, 0, 16'd42);
        run_table(0);

        // Asynchronous reset mid-run at from_pc = 0018, away from any edge.
        check("pre_reset_pc", 9100, from_pc, 16'h0018);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(9101);
        @(posedge clk);
        #1;
        check_reset(9102);
        rst_n = 1'b1;

        add(0, 0, 16'h0000, 16'h0002, 16'hFE21, 16'h0002, 1, 0, 0, 16'd1);
        // PC wrap from FFFE to 0000.
        add(0, 1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0, 16'd1);
        add(0, 0, 16'h0000, 16'h0000, 16'h0FFE, 16'h0000, 1, 0, 0, 16'd2);
        add(0, 0, 16'h0000, 16'h0002, 16'hFE21, 16'h0002, 1, 0, 0, 16'd3);
        run_table(200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter HALT_WORD, default 16'h0000, meaning the instruction encoding treated as HALT.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stall  input  1  hazard unit request to hold PC and IF/ID.
REQ-006 branch_taken  input  1  redirect request from a later stage, one-cycle pulse.
REQ-007 branch_target  input  16  redirect byte address.
REQ-008 instruction  input  16  combinational word returned by instruction memory for from_pc.
REQ-009 from_pc  output  16  fetch address driven to instruction memory, equal to the PC register.
REQ-010 ifid_instruction  output  16  IF/ID buffered instruction.
REQ-011 ifid_pc_plus2  output  16  IF/ID buffered fetch address + 2.
REQ-012 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-013 halted  output  1  fetch has stopped on HALT_WORD.
REQ-014 misalign  output  1  one-cycle pulse when an odd branch_target was accepted.
REQ-015 fetch_count  output  16  count of instructions loaded into IF/ID.

Function
REQ-016 The per-cycle update priority SHALL be: branch_taken, then stall, then normal fetch.
REQ-017 The state machine SHALL have states RUN and HALTED; reset enters RUN.
REQ-018 In RUN with no stall and no branch, IF/ID SHALL load {instruction, from_pc+2, valid=1}, the PC SHALL advance by 2, and fetch_count SHALL increment.
REQ-019 PC arithmetic SHALL be 16-bit modulo, so 16'hFFFE advances to 16'h0000 with no flag.
REQ-020 In RUN, a fetched word equal to HALT_WORD SHALL be loaded into IF/ID as valid, the PC SHALL hold, and the state SHALL move to HALTED, with halted asserted from the next cycle.
REQ-021 In HALTED, the PC SHALL hold, ifid_valid SHALL be 0, ifid_instruction SHALL be 16'h0000, and fetch_count SHALL hold.
REQ-022 On branch_taken in any state, the PC SHALL load {branch_target[15:1],1'b0}, IF/ID SHALL flush to {16'h0000, 16'h0000, valid=0}, the state SHALL move to RUN, and halted SHALL clear next cycle.
REQ-023 When an accepted branch_target has bit 0 set, misalign SHALL pulse for exactly that following cycle.
REQ-024 branch_taken and stall asserted together SHALL resolve as a branch; stall is ignored.
REQ-025 On stall without branch, the PC, IF/ID, state and fetch_count SHALL hold all values; a HALT_WORD present at from_pc during a stall SHALL NOT trigger HALTED.
REQ-026 fetch_count SHALL saturate at 16'hFFFF.
REQ-027 Fetch latency SHALL be one cycle: the word at from_pc in cycle N SHALL appear on ifid_instruction in cycle N+1.

Reset
REQ-028 While rst_n=0, outputs SHALL be: from_pc=RESET_PC, ifid_instruction=0, ifid_pc_plus2=0, ifid_valid=0, halted=0, misalign=0, fetch_count=0, state=RUN.
REQ-029 Reset asserted mid-operation, including in HALTED or during a stall, SHALL take effect immediately and asynchronously; the first fetch after deassertion SHALL be from RESET_PC.

Structure
REQ-030 The state encoding, RESET_PC default, HALT_WORD default and PC increment constant (2) SHALL live in the shared cpu package.
REQ-031 The IF/ID register SHALL be a sub-module named if_id_buffer with load, flush and hold controls; the PC register and FSM SHALL stay in instruction_fetch.

Verification
REQ-032 The bench SHALL cover reset release with the standard program image: cycle 1 gives ifid_instruction=16'hFE21, ifid_pc_plus2=16'h0002, ifid_valid=1, and from_pc=16'h0002.
REQ-033 The bench SHALL cover sequential fetch through 16'h003E (word 16'h0000): ifid_valid=1 for that word, then halted=1, from_pc held at 16'h003E, and fetch_count=32.
REQ-034 The bench SHALL cover a branch_taken pulse with target 16'h002C while HALTED: halted=0 and from_pc=16'h002C next cycle, then ifid_instruction=16'hF111 the cycle after.
REQ-035 The bench SHALL cover stall asserted for 3 cycles at from_pc=16'h0010: IF/ID, from_pc and fetch_count are unchanged, and after release ifid_instruction=16'hCE9A.
REQ-036 The bench SHALL cover branch_taken and stall asserted together with target 16'h0023: from_pc=16'h0022, misalign pulses for 1 cycle, and ifid_valid=0.
REQ-037 The bench SHALL cover rst_n pulsed low mid-run at from_pc=16'h0018: all outputs go to reset values immediately, and the first post-reset IF/ID word is 16'hFE21.
